// File: rtl/complex_sub.sv
// Registered complex subtractor for the FFT butterfly difference leg.
// Per-component overflow flags with optional saturation.
module complex_sub #(
  parameter int DATA_W   = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic [2*DATA_W-1:0] i_A,
  input  logic [2*DATA_W-1:0] i_B,
  output logic [2*DATA_W-1:0] o_diff,
  output logic                o_valid,
  output logic [1:0]          o_ovf
);

  localparam int W = DATA_W;

  logic [W-1:0] re_a, re_b, im_a, im_b;
  logic [W:0]   re_w, im_w;
  logic         re_ovf, im_ovf;
  logic [W-1:0] re_res, im_res;
  logic [W-1:0] pos_max, neg_min;

  logic [2*W-1:0] diff_d, diff_q;
  logic [1:0]     ovf_d, ovf_q;
  logic           valid_d, valid_q;

  // Split halves and subtract each in W+1 bits; halves never share a borrow.
  always_comb begin
    re_a    = i_A[2*W-1:W];
    re_b    = i_B[2*W-1:W];
    im_a    = i_A[W-1:0];
    im_b    = i_B[W-1:0];
    pos_max = {1'b0, {(W-1){1'b1}}};
    neg_min = {1'b1, {(W-1){1'b0}}};
    re_w    = {re_a[W-1], re_a} - {re_b[W-1], re_b};
    im_w    = {im_a[W-1], im_a} - {im_b[W-1], im_b};
    re_ovf  = re_w[W] ^ re_w[W-1];
    im_ovf  = im_w[W] ^ im_w[W-1];
    re_res  = re_w[W-1:0];
    im_res  = im_w[W-1:0];
    if (SATURATE && re_ovf) begin
      re_res = re_a[W-1] ? neg_min : pos_max;
    end
    if (SATURATE && im_ovf) begin
      im_res = im_a[W-1] ? neg_min : pos_max;
    end
  end

  // Capture a new result on valid, otherwise hold data and drop valid.
  always_comb begin
    diff_d  = diff_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (i_valid) begin
      diff_d  = {re_res, im_res};
      ovf_d   = {re_ovf, im_ovf};
      valid_d = 1'b1;
    end
  end

  // Output registers with synchronous reset taking priority over valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      diff_q  <= '0;
      ovf_q   <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      diff_q  <= diff_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign o_diff  = diff_q;
  assign o_ovf   = ovf_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_complex_sub.sv
// Directed bench for complex_sub, wrap and saturating builds side by side.
// Table vectors plus reset, stream/hold and mid-stream reset sequences.
module tb_complex_sub;

  logic        clk;
  logic        rst;
  logic        vld;
  logic [15:0] a, b;
  logic [15:0] diff_w, diff_s;
  logic        vld_w, vld_s;
  logic [1:0]  ovf_w, ovf_s;

  int total = 0;
  int bad   = 0;

  complex_sub #(.DATA_W(8), .SATURATE(1'b0)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_valid(vld),
    .i_A(a), .i_B(b),
    .o_diff(diff_w), .o_valid(vld_w), .o_ovf(ovf_w)
  );

  complex_sub #(.DATA_W(8), .SATURATE(1'b1)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_valid(vld),
    .i_A(a), .i_B(b),
    .o_diff(diff_s), .o_valid(vld_s), .o_ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_w;
    logic [15:0] exp_s;
    logic [1:0]  exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Independent reference per component using integer arithmetic.
  function automatic void ref_comp(input logic [7:0] ca, input logic [7:0] cb,
                                   output logic [7:0] rw, output logic [7:0] rs,
                                   output logic ov);
    int ia, ib, d;
    logic [31:0] du;
    ia = int'($signed(ca));
    ib = int'($signed(cb));
    d  = ia - ib;
    du = d;
    rw = du[7:0];
    ov = (d > 127) || (d < -128);
    if (d > 127)       rs = 8'h7F;
    else if (d < -128) rs = 8'h80;
    else               rs = du[7:0];
  endfunction

  function automatic void ref_model(input logic [15:0] ra, input logic [15:0] rb,
                                    output logic [15:0] ew, output logic [15:0] es,
                                    output logic [1:0] eo);
    logic [7:0] w1, s1, w0, s0;
    logic o1, o0;
    ref_comp(ra[15:8], rb[15:8], w1, s1, o1);
    ref_comp(ra[7:0], rb[7:0], w0, s0, o0);
    ew = {w1, w0};
    es = {s1, s0};
    eo = {o1, o0};
  endfunction

  task automatic chk_out(input string nm, input logic [15:0] ew,
                         input logic [15:0] es, input logic [1:0] eo,
                         input logic ev);
    chk({nm, ".diff_w"}, diff_w, ew);
    chk({nm, ".diff_s"}, diff_s, es);
    chk({nm, ".ovf_w"}, {14'd0, ovf_w}, {14'd0, eo});
    chk({nm, ".ovf_s"}, {14'd0, ovf_s}, {14'd0, eo});
    chk({nm, ".vld_w"}, {15'd0, vld_w}, {15'd0, ev});
    chk({nm, ".vld_s"}, {15'd0, vld_s}, {15'd0, ev});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] ew, es, last_w, last_s;
  logic [1:0]  eo, last_o;
  logic [15:0] sa[3], sb[3];

  initial begin
    vecs[0] = '{16'h0421, 16'h0224, 16'h02FD, 16'h02FD, 2'b00};
    vecs[1] = '{16'hFFFE, 16'hFE05, 16'h01F9, 16'h01F9, 2'b00};
    vecs[2] = '{16'h7F80, 16'hFF01, 16'h807F, 16'h7F80, 2'b11};
    vecs[3] = '{16'h8000, 16'h0100, 16'h7F00, 16'h8000, 2'b10};
    vecs[4] = '{16'h0064, 16'h009C, 16'h00C8, 16'h007F, 2'b01};
    vecs[5] = '{16'h0000, 16'h0001, 16'h00FF, 16'h00FF, 2'b00};
    vecs[6] = '{16'hFF80, 16'h7F00, 16'h8080, 16'h8080, 2'b00};
    vecs[7] = '{16'h7F7F, 16'h8080, 16'hFFFF, 16'h7F7F, 2'b11};

    rst = 1'b1;
    vld = 1'b1;
    a   = 16'h7F80;
    b   = 16'hFF01;
    cyc();
    cyc();
    chk_out("reset", 16'h0000, 16'h0000, 2'b00, 1'b0);

    rst = 1'b0;
    foreach (vecs[i]) begin
      vld = 1'b1;
      a   = vecs[i].a;
      b   = vecs[i].b;
      cyc();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_w, vecs[i].exp_s,
              vecs[i].exp_ovf, 1'b1);
    end

    vld = 1'b0;
    a   = 16'h1234;
    b   = 16'h5678;
    cyc();
    chk_out("hold", 16'hFFFF, 16'h7F7F, 2'b11, 1'b0);

    sa[0] = 16'h1050; sb[0] = 16'h2030;
    sa[1] = 16'h80C0; sb[1] = 16'h7F50;
    sa[2] = 16'h3333; sb[2] = 16'hCCCC;
    for (int i = 0; i < 3; i++) begin
      vld = 1'b1;
      a   = sa[i];
      b   = sb[i];
      cyc();
      ref_model(sa[i], sb[i], ew, es, eo);
      chk_out($sformatf("stream%0d", i), ew, es, eo, 1'b1);
      last_w = ew;
      last_s = es;
      last_o = eo;
    end
    vld = 1'b0;
    a   = 16'h0000;
    b   = 16'h7F7F;
    cyc();
    chk_out("stream_hold0", last_w, last_s, last_o, 1'b0);
    cyc();
    chk_out("stream_hold1", last_w, last_s, last_o, 1'b0);

    vld = 1'b1;
    a   = 16'h7F7F;
    b   = 16'h8080;
    cyc();
    chk_out("pre_rst", 16'hFFFF, 16'h7F7F, 2'b11, 1'b1);
    rst = 1'b1;
    a   = 16'h0421;
    b   = 16'h0224;
    cyc();
    chk_out("mid_rst", 16'h0000, 16'h0000, 2'b00, 1'b0);
    rst = 1'b0;
    cyc();
    chk_out("post_rst", 16'h02FD, 16'h02FD, 2'b00, 1'b1);
    vld = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
